range_cfg_loader: RTL and testbench
===================================

Name: range_cfg_loader

Overview:
- Programming master for the bank of sniffer range comparators.
- Accepts range-configuration commands over a valid/ready port from the Zynq PS register block.
- Drives the shared bound buses and the per-comparator one-hot latch strobes, sequencing lower and upper bounds on separate cycles.
- Gates each comparator's compare-enable so no comparator evaluates a half-updated range.

Parameters:
- WIDTH, 32, bound/address width; must match the comparator WIDTH.
- NUM_RANGES, 4, number of comparators driven.
- IDX_W, 2, command index width; 2**IDX_W >= NUM_RANGES.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader can accept; equals (state==IDLE)
- cmd_op  in  1  0=LOAD range, 1=DISABLE range
- cmd_idx  in  IDX_W  target comparator
- cmd_lo  in  WIDTH  lower bound (LOAD only)
- cmd_hi  in  WIDTH  upper bound (LOAD only)
- sniff_en  in  1  global sniff enable
- lA  out  WIDTH  shared lower-bound bus to all comparators
- uA  out  WIDTH  shared upper-bound bus to all comparators
- take_lA  out  NUM_RANGES  one-hot lower-bound latch strobe
- take_uA  out  NUM_RANGES  one-hot upper-bound latch strobe
- cmp_enable  out  NUM_RANGES  per-comparator compare enable
- cmd_done  out  1  one-cycle pulse: command completed
- cmd_err  out  1  one-cycle pulse: command rejected

Behaviour:
- All outputs are registered except cmd_ready.
- Reset values:
  - lA = uA = all-ones.
  - take_lA = take_uA = 0.
  - cmp_enable = 0, active[] = 0.
  - cmd_done = cmd_err = 0.
  - state = IDLE.
- Reset mid-command aborts the command; all state returns to reset values.
- States: IDLE, LOAD_LO, LOAD_HI, DONE.
- Accept at edge E0: state==IDLE and cmd_valid. Sample cmd_* at E0.
- Error check at E0:
  - Error if cmd_idx >= NUM_RANGES, or if op=LOAD and cmd_lo > cmd_hi (unsigned).
  - On error: go to DONE with cmd_err=1 for that cycle. No other register changes.
- LOAD, valid:
  - E0: cmp_enable[idx] <= 0, active[idx] <= 0; lA <= cmd_lo; take_lA <= onehot(idx); hi latched internally; state <= LOAD_LO.
  - E1: take_lA <= 0; uA <= hi; take_uA <= onehot(idx); state <= LOAD_HI. The comparator latches lA at E1.
  - E2: take_uA <= 0; active[idx] <= 1; cmp_enable[idx] <= sniff_en; cmd_done <= 1; state <= DONE. The comparator latches uA at E2.
  - E3: cmd_done <= 0; state <= IDLE.
- take_lA and take_uA are never high in the same cycle. The comparator gives take_lA priority and would drop take_uA, so this is mandatory.
- DISABLE, valid:
  - E0: active[idx] <= 0, cmp_enable[idx] <= 0, cmd_done <= 1, state <= DONE.
  - E1: state <= IDLE.
- Throughput:
  - LOAD: cmd_ready low for 3 cycles; next accept no earlier than E3.
  - DISABLE and error: cmd_ready low for 1 cycle.
- Steady state, i not under command: cmp_enable[i] <= sniff_en & active[i], registered, 1-cycle latency from sniff_en.
- lA and uA hold their last driven value when idle. Strobes are zero when idle.
- cmd_valid while not IDLE is ignored. The command stays pending per valid/ready rules and the master must hold cmd_* stable.
- Reprogramming an already-active index is legal. Its cmp_enable is low from E0 through E2 and re-asserts at E2. Other indices' cmp_enable are unaffected throughout.
- Boundary: cmd_lo == cmd_hi is valid (single-address range). lo=0, hi=all-ones is valid (full range).

Decomposition:
- Shared package sniffer_pkg holds:
  - state encoding: IDLE=0, LOAD_LO=1, LOAD_HI=2, DONE=3.
  - op encodings: OP_LOAD=0, OP_DISABLE=1.
  - BOUND_RST constant (all-ones).
- No sub-module. The one-hot index decode is inline in the register process.

Test Plan:
- Reset, then sniff_en=1, LOAD idx=2 lo=0x1000 hi=0x1FFF:
  - take_lA=4'b0100 with lA=0x1000 in the cycle after accept.
  - take_uA=4'b0100 with uA=0x1FFF in the next cycle.
  - cmp_enable[2] and cmd_done high in the third cycle; cmd_ready low for exactly 3 cycles.
- LOAD idx=1 lo=0x2000 hi=0x1000:
  - cmd_err pulse 1 cycle after accept; no take strobe; cmp_enable unchanged; cmd_ready back high after 1 cycle.
- LOAD idx=5 with NUM_RANGES=4 → cmd_err pulse; no strobes.
- Reprogram active idx 0 to lo=hi=0xABCD while idx 3 is active:
  - cmp_enable[0] low during LOAD_LO and LOAD_HI.
  - cmp_enable[3] stays high throughout.
  - take_lA and take_uA never overlap.
- DISABLE idx=3 → cmp_enable[3]=0 at next edge and cmd_done pulse; toggling sniff_en afterwards leaves cmp_enable[3]=0.
- Assert reset during LOAD_HI:
  - All outputs go to reset values immediately, with lA=uA=0xFFFFFFFF.
  - After release, cmd_ready=1 and cmp_enable=0.

Source files
------------

// File: rtl/range_cfg_loader_pkg.sv
// Shared encodings for the sniffer range-comparator programming path.
// State, opcode and bound reset constants used by the loader and its bench.
package sniffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_LO = 2'd1,
        LOAD_HI = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_DISABLE = 1'b1;

    // Bounds park at all-ones; consumers slice to their own width.
    localparam logic [63:0] BOUND_RST = '1;

endpackage

// File: rtl/range_cfg_loader_if.sv
// Command port between the PS register block and the range loader.
// Valid/ready request plus one-cycle done/error completion pulses.
interface range_cfg_loader_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [WIDTH-1:0] cmd_lo;
    logic [WIDTH-1:0] cmd_hi;
    logic             cmd_done;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_lo, cmd_hi,
        input  cmd_ready, cmd_done, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_lo, cmd_hi,
        output cmd_ready, cmd_done, cmd_err
    );
endinterface

// File: rtl/range_cfg_loader.sv
// Programs the sniffer range comparators over shared bound buses,
// strobing lower then upper bound and gating compare-enable meanwhile.
module range_cfg_loader
    import sniffer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_RANGES = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    range_cfg_loader_if.slave     bus,
    input  logic                  sniff_en,
    output logic [WIDTH-1:0]      lA,
    output logic [WIDTH-1:0]      uA,
    output logic [NUM_RANGES-1:0] take_lA,
    output logic [NUM_RANGES-1:0] take_uA,
    output logic [NUM_RANGES-1:0] cmp_enable
);

    localparam logic [WIDTH-1:0] BRST = BOUND_RST[WIDTH-1:0];

    state_t                state;
    logic [NUM_RANGES-1:0] active;
    logic [NUM_RANGES-1:0] tgt_oh;
    logic [WIDTH-1:0]      hi_q;
    logic                  done_q;
    logic                  err_q;

    function automatic logic [NUM_RANGES-1:0] onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [NUM_RANGES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_RANGES; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    logic bad_idx;
    logic bad_rng;
    logic bad_cmd;

    // Reject out-of-range indices and inverted bounds at accept time.
    always_comb begin
        bad_idx = ({1'b0, bus.cmd_idx} >= (IDX_W+1)'(NUM_RANGES));
        bad_rng = (bus.cmd_op == OP_LOAD) && (bus.cmd_lo > bus.cmd_hi);
        bad_cmd = bad_idx || bad_rng;
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.cmd_done  = done_q;
    assign bus.cmd_err   = err_q;

    // Command sequencer, bound buses, strobes and enable gating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lA         <= BRST;
            uA         <= BRST;
            take_lA    <= '0;
            take_uA    <= '0;
            cmp_enable <= '0;
            active     <= '0;
            tgt_oh     <= '0;
            hi_q       <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cmp_enable <= {NUM_RANGES{sniff_en}} & active;
            take_lA    <= '0;
            take_uA    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bad_cmd) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (bus.cmd_op == OP_DISABLE) begin
                            active     <= active & ~onehot(bus.cmd_idx);
                            cmp_enable <= {NUM_RANGES{sniff_en}} & active
                                          & ~onehot(bus.cmd_idx);
                            done_q     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            active     <= active & ~onehot(bus.cmd_idx);
                            cmp_enable <= {NUM_RANGES{sniff_en}} & active
                                          & ~onehot(bus.cmd_idx);
                            lA         <= bus.cmd_lo;
                            take_lA    <= onehot(bus.cmd_idx);
                            tgt_oh     <= onehot(bus.cmd_idx);
                            hi_q       <= bus.cmd_hi;
                            state      <= LOAD_LO;
                        end
                    end
                end
                LOAD_LO: begin
                    uA      <= hi_q;
                    take_uA <= tgt_oh;
                    state   <= LOAD_HI;
                end
                LOAD_HI: begin
                    active     <= active | tgt_oh;
                    cmp_enable <= {NUM_RANGES{sniff_en}} & (active | tgt_oh);
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_cfg_loader.sv
// Directed bench for range_cfg_loader: command table plus
// hand sequences for sniff_en toggling and mid-command reset.
module tb_range_cfg_loader;
    import sniffer_pkg::*;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int IW = 3;

    logic          clk;
    logic          reset;
    logic          sniff_en;
    logic [W-1:0]  lA;
    logic [W-1:0]  uA;
    logic [NR-1:0] take_lA;
    logic [NR-1:0] take_uA;
    logic [NR-1:0] cmp_enable;

    int n_cmp;
    int n_bad;

    range_cfg_loader_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    range_cfg_loader #(
        .WIDTH(W), .NUM_RANGES(NR), .IDX_W(IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sniff_en   (sniff_en),
        .lA         (lA),
        .uA         (uA),
        .take_lA    (take_lA),
        .take_uA    (take_uA),
        .cmp_enable (cmp_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          op;
        logic [IW-1:0] idx;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        logic          err;
        logic [NR-1:0] en_after;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobes must never overlap: the comparator would drop take_uA.
    always @(negedge clk) begin
        if (reset) chk("strobe_overlap", W'(take_lA & take_uA), '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input vec_t v);
        logic [NR-1:0] oh;
        oh = '0;
        if (int'(v.idx) < NR) oh[v.idx] = 1'b1;
        chk("ready_pre", W'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_idx   = v.idx;
        bus.cmd_lo    = v.lo;
        bus.cmd_hi    = v.hi;
        tick();
        bus.cmd_valid = 1'b0;
        chk("ready_e0", W'(bus.cmd_ready), 0);
        if (v.err) begin
            chk("err_e0", W'(bus.cmd_err), 1);
            chk("done_e0", W'(bus.cmd_done), 0);
            chk("tl_e0", W'(take_lA), 0);
            chk("tu_e0", W'(take_uA), 0);
            chk("en_e0", W'(cmp_enable), W'(v.en_after));
            tick();
            chk("err_e1", W'(bus.cmd_err), 0);
            chk("ready_e1", W'(bus.cmd_ready), 1);
        end else if (v.op == OP_DISABLE) begin
            chk("done_e0", W'(bus.cmd_done), 1);
            chk("err_e0", W'(bus.cmd_err), 0);
            chk("en_e0", W'(cmp_enable), W'(v.en_after));
            tick();
            chk("done_e1", W'(bus.cmd_done), 0);
            chk("ready_e1", W'(bus.cmd_ready), 1);
        end else begin
            chk("tl_e0", W'(take_lA), W'(oh));
            chk("lA_e0", lA, v.lo);
            chk("tu_e0", W'(take_uA), 0);
            chk("en_e0", W'(cmp_enable), W'(v.en_after & ~oh));
            tick();
            chk("ready_e1", W'(bus.cmd_ready), 0);
            chk("tl_e1", W'(take_lA), 0);
            chk("tu_e1", W'(take_uA), W'(oh));
            chk("uA_e1", uA, v.hi);
            chk("lA_e1", lA, v.lo);
            chk("en_e1", W'(cmp_enable), W'(v.en_after & ~oh));
            tick();
            chk("ready_e2", W'(bus.cmd_ready), 0);
            chk("done_e2", W'(bus.cmd_done), 1);
            chk("tu_e2", W'(take_uA), 0);
            chk("en_e2", W'(cmp_enable), W'(v.en_after));
            tick();
            chk("ready_e3", W'(bus.cmd_ready), 1);
            chk("done_e3", W'(bus.cmd_done), 0);
        end
    endtask

    vec_t vecs[8];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{OP_LOAD,    3'd2, 32'h1000, 32'h1FFF,     1'b0, 4'b0100};
        vecs[1] = '{OP_LOAD,    3'd1, 32'h2000, 32'h1000,     1'b1, 4'b0100};
        vecs[2] = '{OP_LOAD,    3'd5, 32'h0001, 32'h0002,     1'b1, 4'b0100};
        vecs[3] = '{OP_LOAD,    3'd3, 32'h0,    32'hFFFFFFFF, 1'b0, 4'b1100};
        vecs[4] = '{OP_LOAD,    3'd0, 32'h10,   32'h20,       1'b0, 4'b1101};
        vecs[5] = '{OP_LOAD,    3'd0, 32'hABCD, 32'hABCD,     1'b0, 4'b1101};
        vecs[6] = '{OP_DISABLE, 3'd3, 32'h0,    32'h0,        1'b0, 4'b0101};
        vecs[7] = '{OP_DISABLE, 3'd7, 32'h0,    32'h0,        1'b1, 4'b0101};

        reset         = 1'b0;
        sniff_en      = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_idx   = '0;
        bus.cmd_lo    = '0;
        bus.cmd_hi    = '0;
        repeat (2) tick();
        chk("rst_lA", lA, 32'hFFFFFFFF);
        chk("rst_uA", uA, 32'hFFFFFFFF);
        chk("rst_tl", W'(take_lA), 0);
        chk("rst_tu", W'(take_uA), 0);
        chk("rst_en", W'(cmp_enable), 0);
        chk("rst_done", W'(bus.cmd_done), 0);
        chk("rst_err", W'(bus.cmd_err), 0);
        chk("rst_ready", W'(bus.cmd_ready), 1);

        reset    = 1'b1;
        sniff_en = 1'b1;
        tick();
        chk("idle_en", W'(cmp_enable), 0);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        chk("hold_lA", lA, 32'hABCD);
        chk("hold_uA", uA, 32'hABCD);

        sniff_en = 1'b0;
        tick();
        chk("sniff_off", W'(cmp_enable), 0);
        sniff_en = 1'b1;
        tick();
        chk("sniff_on", W'(cmp_enable), 4'b0101);

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_idx   = 3'd1;
        bus.cmd_lo    = 32'h5;
        bus.cmd_hi    = 32'h9;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("mid_tu", W'(take_uA), 4'b0010);
        reset = 1'b0;
        #1;
        chk("arst_lA", lA, 32'hFFFFFFFF);
        chk("arst_uA", uA, 32'hFFFFFFFF);
        chk("arst_tl", W'(take_lA), 0);
        chk("arst_tu", W'(take_uA), 0);
        chk("arst_en", W'(cmp_enable), 0);
        chk("arst_done", W'(bus.cmd_done), 0);
        chk("arst_ready", W'(bus.cmd_ready), 1);
        #3;
        reset = 1'b1;
        repeat (2) tick();
        chk("post_ready", W'(bus.cmd_ready), 1);
        chk("post_en", W'(cmp_enable), 0);
        chk("post_tu", W'(take_uA), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
